// File: rtl/serial_alu_sequencer_if.sv
// serial_alu_sequencer_if: request/operand bus from register-read and result/flag bus to writeback.
interface serial_alu_sequencer_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             op_err;
  modport master (output start, op, a, b, input busy, done, result, cout, ovf, zero, op_err);
  modport slave (input start, op, a, b, output busy, done, result, cout, ovf, zero, op_err);
endinterface

// File: rtl/serial_alu_sequencer.sv
// serial_alu_sequencer: bit-serial ALU walking a one-bit slice LSB->MSB with a registered carry.
module serial_alu_sequencer #(
  parameter int WIDTH = 32
) (
  input logic                   clk,
  input logic                   rst_n,
  serial_alu_sequencer_if.slave bus_if
);
  localparam int IW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, result_q, result_d;
  logic             busy_q, done_q, cout_q, ovf_q, zero_q, op_err_q;
  logic             ai, bi, bp, arith, r_bit, carry_d, legal, last;
  always_comb begin
    ai       = a_q[idx_q];
    bi       = b_q[idx_q];
    bp       = bi ^ op_q[2];
    arith    = op_q[1:0] == 2'b10;
    carry_d  = (ai & bp) | (carry_q & (ai ^ bp));
    r_bit    = op_q == 3'b000 ? ai & bi :
               op_q == 3'b001 ? ai | bi :
               op_q == 3'b111 ? ai ^ bi : ai ^ bp ^ carry_q;
    result_d = result_q;
    result_d[idx_q] = r_bit;
    legal    = bus_if.op inside {3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
    last     = idx_q == IW'(WIDTH - 1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      op_err_q <= 1'b0;
    end else if (state_q == IDLE) begin
      if (bus_if.start) begin
        a_q      <= bus_if.a;
        b_q      <= bus_if.b;
        op_q     <= bus_if.op;
        idx_q    <= '0;
        carry_q  <= bus_if.op[2];
        result_q <= '0;
        cout_q   <= 1'b0;
        ovf_q    <= 1'b0;
        busy_q   <= 1'b1;
        done_q   <= !legal;
        zero_q   <= !legal;
        op_err_q <= !legal;
        state_q  <= legal ? RUN : DONE;
      end
    end else if (state_q == RUN) begin
      result_q <= result_d;
      idx_q    <= idx_q + 1'b1;
      if (arith) carry_q <= carry_d;
      if (last) begin
        // carry_q here is the carry into the MSB slice, carry_d the carry out of it
        cout_q  <= arith & carry_d;
        ovf_q   <= arith & (carry_q ^ carry_d);
        zero_q  <= result_d == '0;
        done_q  <= 1'b1;
        state_q <= DONE;
      end
    end else begin
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      state_q <= IDLE;
    end
  end
  assign bus_if.busy   = busy_q;
  assign bus_if.done   = done_q;
  assign bus_if.result = result_q;
  assign bus_if.cout   = cout_q;
  assign bus_if.ovf    = ovf_q;
  assign bus_if.zero   = zero_q;
  assign bus_if.op_err = op_err_q;
endmodule

// File: tb/tb_serial_alu_sequencer.sv
// tb_serial_alu_sequencer: directed and random operations checked against an arithmetic reference model.
module tb_serial_alu_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  serial_alu_sequencer_if #(.WIDTH(32)) bus_if ();
  serial_alu_sequencer #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus_if(bus_if));
  typedef struct packed {
    logic [31:0] r;
    logic        c;
    logic        v;
    logic        z;
    logic        e;
  } exp_t;
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        x;
    logic [32:0] s;
    x = '0;
    if (op == 3'b000) x.r = a & b;
    else if (op == 3'b001) x.r = a | b;
    else if (op == 3'b111) x.r = a ^ b;
    else if (op == 3'b010) begin
      s   = {1'b0, a} + {1'b0, b};
      x.r = s[31:0];
      x.c = s[32];
      x.v = (a[31] == b[31]) && (s[31] != a[31]);
    end else if (op == 3'b110) begin
      s   = {1'b0, a} + {1'b0, ~b} + 33'd1;
      x.r = s[31:0];
      x.c = s[32];
      x.v = (a[31] != b[31]) && (s[31] != a[31]);
    end else x.e = 1'b1;
    x.z = x.r == 32'd0;
    return x;
  endfunction
  // Caller is at a negedge in IDLE; returns at the negedge of the first IDLE cycle after DONE.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit repulse, input string tag);
    exp_t x;
    int   cyc;
    int   want;
    x = model(op, a, b);
    want = x.e ? 1 : 33;
    bus_if.start = 1'b1;
    bus_if.op = op;
    bus_if.a = a;
    bus_if.b = b;
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.a = $urandom;
    bus_if.b = $urandom;
    bus_if.op = 3'($urandom);
    cyc = 1;
    while (!bus_if.done && cyc < 100) begin
      if (cyc == 11 && !x.e) begin
        checks++;
        if (bus_if.result !== {22'd0, x.r[9:0]} || bus_if.busy !== 1'b1) begin
          errors++;
          $display("FAIL %s partial: result=%h busy=%b expected %h busy=1", tag, bus_if.result,
                   bus_if.busy, {22'd0, x.r[9:0]});
        end
      end
      bus_if.start = repulse && cyc == 5;
      @(negedge clk);
      cyc++;
    end
    bus_if.start = 1'b0;
    checks++;
    if (cyc !== want) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", tag, cyc, want);
    end
    checks++;
    if ({bus_if.result, bus_if.cout, bus_if.ovf, bus_if.zero, bus_if.op_err} !== x) begin
      errors++;
      $display("FAIL %s result: got r=%h c=%b v=%b z=%b e=%b expected r=%h c=%b v=%b z=%b e=%b", tag,
               bus_if.result, bus_if.cout, bus_if.ovf, bus_if.zero, bus_if.op_err,
               x.r, x.c, x.v, x.z, x.e);
    end
    checks++;
    if (bus_if.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_done: got %b expected 1", tag, bus_if.busy);
    end
    @(negedge clk);
    checks++;
    if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.result !== x.r || bus_if.zero !== x.z) begin
      errors++;
      $display("FAIL %s hold: done=%b busy=%b r=%h z=%b expected done=0 busy=0 r=%h z=%b", tag,
               bus_if.done, bus_if.busy, bus_if.result, bus_if.zero, x.r, x.z);
    end
  endtask
  task automatic test_reset();
    #1;
    checks++;
    if ({bus_if.busy, bus_if.done, bus_if.result, bus_if.cout, bus_if.ovf, bus_if.zero, bus_if.op_err} !== '0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b r=%h expected all zero", bus_if.busy, bus_if.done, bus_if.result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_directed();
    run_op(3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, "and");
    run_op(3'b010, 32'hFFFFFFFF, 32'h00000001, 1'b0, "add_wrap");
    run_op(3'b110, 32'h00000005, 32'h00000007, 1'b0, "sub_neg");
    run_op(3'b110, 32'h80000000, 32'h00000001, 1'b0, "sub_ovf");
    run_op(3'b010, 32'h7FFFFFFF, 32'h00000001, 1'b0, "add_ovf");
    run_op(3'b011, 32'h12345678, 32'h9ABCDEF0, 1'b0, "illegal");
  endtask
  task automatic test_repulse();
    run_op(3'b111, 32'hAAAAAAAA, 32'hFFFFFFFF, 1'b1, "xor_repulse");
  endtask
  task automatic test_abort();
    int cyc;
    bit seen;
    bus_if.start = 1'b1;
    bus_if.op = 3'b010;
    bus_if.a = 32'h0000FFFF;
    bus_if.b = 32'h00000FFF;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus_if.busy, bus_if.done, bus_if.result, bus_if.cout, bus_if.ovf, bus_if.zero, bus_if.op_err} !== '0) begin
      errors++;
      $display("FAIL abort: busy=%b done=%b r=%h expected all zero", bus_if.busy, bus_if.done, bus_if.result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      seen |= bus_if.done;
    end
    checks++;
    if (seen !== 1'b0 || bus_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet: done_seen=%b busy=%b expected 0 0", seen, bus_if.busy);
    end
    run_op(3'b001, 32'h00F0000F, 32'h0F00F000, 1'b0, "or_after_abort");
  endtask
  task automatic test_back_to_back();
    run_op(3'b010, 32'h80000000, 32'h80000000, 1'b0, "b2b_add");
    run_op(3'b110, 32'h00000000, 32'h00000000, 1'b0, "b2b_sub");
    run_op(3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "b2b_illegal");
    run_op(3'b000, 32'h0F0F0F0F, 32'hF0F0F0F0, 1'b0, "b2b_and_zero");
  endtask
  task automatic test_random();
    logic [2:0] ops[8] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b011, 3'b100, 3'b101};
    for (int i = 0; i < 24; i++)
      run_op(ops[$urandom_range(7)], $urandom, (i % 6 == 5) ? 32'hFFFFFFFF : $urandom, i % 4 == 2, "random");
  endtask
  initial begin
    bus_if.start = 1'b0;
    bus_if.op = 3'b000;
    bus_if.a = '0;
    bus_if.b = '0;
    test_reset();
    test_directed();
    test_repulse();
    test_abort();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
